// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-request handshake and serial-line bundle for uart_tx.
//               master = byte producer (drives tx_req/tx_data),
//               slave  = transmitter (drives tx, tx_ready, tx_busy, tx_done).
// Signals     : tx_req   - byte-valid request, sampled on rising clock edge
//               tx_data  - byte to send, sampled together with tx_req
//               tx       - serial line, idle high
//               tx_ready - holding register empty, a byte can be accepted
//               tx_busy  - a frame is on the line (START through STOP)
//               tx_done  - one-cycle pulse on the last cycle of each frame
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_req,
        output tx_data,
        input  tx,
        input  tx_ready,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_req,
        input  tx_data,
        output tx,
        output tx_ready,
        output tx_busy,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter with a 1-deep holding register.
//               Frame: start(0), data bits 7..0 (MSB first), parity, stop(1),
//               every bit held CLKS_PER_BIT clocks. A queued byte follows the
//               previous stop bit with no idle gap.
// Parameters  : CLKS_PER_BIT - clk_3125 cycles per serial bit
//               PARITY_ODD   - 0 = even parity, 1 = odd parity
// Ports       : clk_3125 - sole clock, rising edge
//               rst_n    - asynchronous active-low reset
//               bus      - uart_tx_if.slave (tx_req/tx_data in;
//                          tx/tx_ready/tx_busy/tx_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int PARITY_ODD   = 0
) (
    input  wire logic clk_3125,
    input  wire logic rst_n,
    uart_tx_if.slave  bus
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             PAR_INV  = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       frame_data;
    logic             parity_bit;
    logic             tx_line;

    logic [7:0]       hold_data;
    logic             hold_full;

    logic             bit_end;
    logic             accept;
    logic             load;
    logic [2:0]       next_idx;

    assign bit_end  = (bit_cnt == CNT_LAST);
    assign accept   = bus.tx_req && !hold_full;
    // A held byte starts a frame either straight from idle or at the very
    // last cycle of a stop bit, which is what makes back-to-back seamless.
    assign load     = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));
    assign next_idx = bit_idx - 3'd1;

    // Holding register. load and accept are mutually exclusive: load needs
    // the register full, accept needs it empty, so a request arriving while
    // full is simply dropped.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= bus.tx_data;
        end
    end

    // Frame sequencer. The frame byte and its parity are copied out of the
    // holding register at load, so later tx_data activity cannot reach them.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            frame_data <= 8'h00;
            parity_bit <= 1'b0;
            tx_line    <= 1'b1;
        end else if (load) begin
            state      <= START;
            bit_cnt    <= '0;
            frame_data <= hold_data;
            parity_bit <= (^hold_data) ^ PAR_INV;
            tx_line    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tx_line <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        bit_idx <= 3'd7;
                        tx_line <= frame_data[7];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd0) begin
                            state   <= PARITY;
                            tx_line <= parity_bit;
                        end else begin
                            bit_idx <= next_idx;
                            tx_line <= frame_data[next_idx];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx_line <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    // The back-to-back case is taken by the load branch.
                    if (bit_end) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tx_line <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tx_line <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx       = tx_line;
    assign bus.tx_ready = !hold_full;
    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_done  = (state == STOP) && bit_end;

endmodule
`default_nettype wire
